// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: NOP word, pc_src encodings, opcodes and
// the fetch FSM state type.
package mips_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic {
    FETCH_REQ  = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory port of the fetch stage.
// Handshake: the request transfers in a cycle with req && gnt. rvalid then
// pulses exactly once per granted request, in order, at least one cycle later.
interface if_fetch_stage_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {inst, pc4} holding buffer for a response that lands during a stall.
// clear has priority over push, push over pop.
module fetch_skid_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [31:0]       in_inst,
  input  logic [ADDR_W-1:0] in_pc4,
  output logic              full,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc4
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full     <= 1'b0;
      out_inst <= '0;
      out_pc4  <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (push) begin
      full     <= 1'b1;
      out_inst <= in_inst;
      out_pc4  <= in_pc4;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC, imem request FSM, skid buffer and IF/ID.
// Optional `define FETCH_PERF_CNT_EN adds perf_fetched / perf_killed counters.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           pc_src,
  input  logic [ADDR_W-1:0]    id_pc4,
  input  logic [15:0]          id_imm16,
  input  logic [25:0]          id_jaddr26,
  input  logic                 stall,
  if_fetch_stage_if.master     imem,
  output logic [31:0]          if_id_inst,
  output logic [ADDR_W-1:0]    if_id_pc4,
  output logic                 if_id_valid,
  output fetch_state_e         dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_killed
`endif
);

  fetch_state_e      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, req_pc4, req_pc4_n;
  logic              kill, kill_n;
  logic              ifid_load, ifid_valid_n;
  logic [31:0]       ifid_inst_n;
  logic [ADDR_W-1:0] ifid_pc4_n;
  logic              skid_push, skid_pop, skid_clear, skid_full;
  logic [31:0]       skid_inst;
  logic [ADDR_W-1:0] skid_pc4;
  logic              redirect;
  logic [ADDR_W-1:0] branch_tgt, jump_tgt, target;

  // Stall wins over a redirect; ID re-presents the redirect next cycle.
  assign redirect   = !stall && (pc_src == PCSRC_BR || pc_src == PCSRC_JMP);
  assign branch_tgt = id_pc4 + {{(ADDR_W-18){id_imm16[15]}}, id_imm16, 2'b00};
  assign jump_tgt   = {id_pc4[ADDR_W-1:28], id_jaddr26, 2'b00};
  assign target     = (pc_src == PCSRC_JMP) ? jump_tgt : branch_tgt;

  assign imem.req   = rst && (state == FETCH_REQ);
  assign imem.addr  = pc;
  assign dbg_state  = state;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    kill_n       = kill;
    req_pc4_n    = req_pc4;
    ifid_load    = !stall;
    ifid_inst_n  = NOP_INST;
    ifid_pc4_n   = '0;
    ifid_valid_n = 1'b0;
    skid_push    = 1'b0;
    skid_pop     = 1'b0;
    skid_clear   = 1'b0;
    case (state)
      FETCH_REQ: begin
        if (imem.gnt) begin
          state_n   = FETCH_WAIT;
          pc_n      = pc + ADDR_W'(4);
          req_pc4_n = pc + ADDR_W'(4);
          kill_n    = redirect;
        end
      end
      FETCH_WAIT: begin
        if (skid_full) begin
          if (redirect) begin
            skid_clear = 1'b1;
            state_n    = FETCH_REQ;
          end else if (!stall) begin
            skid_pop     = 1'b1;
            ifid_inst_n  = skid_inst;
            ifid_pc4_n   = skid_pc4;
            ifid_valid_n = 1'b1;
            state_n      = FETCH_REQ;
          end
        end else if (imem.rvalid) begin
          state_n = FETCH_REQ;
          kill_n  = 1'b0;
          if (kill || redirect) begin
            state_n = FETCH_REQ;
          end else if (stall) begin
            skid_push = 1'b1;
            state_n   = FETCH_WAIT;
          end else begin
            ifid_inst_n  = imem.rdata;
            ifid_pc4_n   = req_pc4;
            ifid_valid_n = 1'b1;
          end
        end else if (redirect) begin
          kill_n = 1'b1;
        end
      end
      default: state_n = FETCH_REQ;
    endcase
    if (redirect) pc_n = target;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH_REQ;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      req_pc4     <= '0;
      if_id_inst  <= NOP_INST;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      kill    <= kill_n;
      req_pc4 <= req_pc4_n;
      if (ifid_load) begin
        if_id_inst  <= ifid_inst_n;
        if_id_pc4   <= ifid_pc4_n;
        if_id_valid <= ifid_valid_n;
      end
    end
  end

  fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (skid_push),
    .pop      (skid_pop),
    .clear    (skid_clear),
    .in_inst  (imem.rdata),
    .in_pc4   (req_pc4),
    .full     (skid_full),
    .out_inst (skid_inst),
    .out_pc4  (skid_pc4)
  );

`ifdef FETCH_PERF_CNT_EN
  logic fetched_inc, killed_inc;
  assign fetched_inc = ifid_load && ifid_valid_n;
  assign killed_inc  = skid_clear ||
                       (state == FETCH_WAIT && !skid_full && imem.rvalid && (kill || redirect));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_killed  <= '0;
    end else begin
      if (fetched_inc) perf_fetched <= perf_fetched + 32'd1;
      if (killed_inc)  perf_killed  <= perf_killed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a small latency-programmable imem.
module tb_if_fetch_stage;
  import mips_pkg::*;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        pc_src = 2'b00;
  logic [ADDR_W-1:0] id_pc4 = '0;
  logic [15:0]       id_imm16 = '0;
  logic [25:0]       id_jaddr26 = '0;
  logic              stall = 1'b0;
  logic [31:0]       if_id_inst;
  logic [ADDR_W-1:0] if_id_pc4;
  logic              if_id_valid;
  fetch_state_e      dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       perf_fetched, perf_killed;
  int                exp_fetched = 0;
  int                exp_killed = 0;
`endif

  int n_checks = 0;
  int n_err = 0;
  logic [31:0] gnt_q[$];

  if_fetch_stage_if #(.ADDR_W(ADDR_W)) imem ();

  if_fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_src      (pc_src),
    .id_pc4      (id_pc4),
    .id_imm16    (id_imm16),
    .id_jaddr26  (id_jaddr26),
    .stall       (stall),
    .imem        (imem),
    .if_id_inst  (if_id_inst),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .dbg_state   (dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_killed (perf_killed)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- instruction memory model ----------------
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  logic        gnt_en = 1'b0;
  int          mem_lat = 1;
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  assign imem.gnt    = gnt_en && imem.req;
  assign imem.rvalid = mem_pend && (mem_cnt == 1);
  assign imem.rdata  = imem.rvalid ? inst_of(mem_addr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (imem.req && imem.gnt) begin
      mem_pend <= 1'b1;
      mem_cnt  <= mem_lat;
      mem_addr <= imem.addr;
      gnt_q.push_back(imem.addr);
    end else if (mem_pend) begin
      if (mem_cnt == 1) mem_pend <= 1'b0;
      else              mem_cnt  <= mem_cnt - 1;
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_gnt(input string tag, input logic [31:0] exp);
    logic [31:0] got;
    got = 32'hFFFF_FFFF;
    if (gnt_q.size() != 0) got = gnt_q.pop_front();
    chk(tag, got, exp);
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n;
    n = 0;
    step();
    while (!if_id_valid && n < max) begin
      step();
      n++;
    end
    n_checks++;
    assert (if_id_valid === 1'b1) else begin
      n_err++;
      $error("FAIL %s: if_id_valid observed=%b expected=1 within %0d cycles", tag, if_id_valid, max);
    end
  endtask

  task automatic note_fetch();
`ifdef FETCH_PERF_CNT_EN
    exp_fetched++;
`endif
  endtask

  task automatic note_kill();
`ifdef FETCH_PERF_CNT_EN
    exp_killed++;
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    step(); step();
    chk("rst_req",   32'(imem.req), 32'd0);
    chk("rst_addr",  imem.addr, 32'h0);
    chk("rst_inst",  if_id_inst, 32'h0);
    chk("rst_pc4",   if_id_pc4, 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(FETCH_REQ));

    // Sequential fetch, grant immediately, rvalid one cycle later
    rst = 1'b1; gnt_en = 1'b1;
    step();
    chk("seq_state_wait", 32'(dbg_state), 32'(FETCH_WAIT));
    pop_gnt("seq_addr0", 32'h0);
    step();
    chk("seq_v0", 32'(if_id_valid), 32'd1);
    chk("seq_i0", if_id_inst, inst_of(32'h0));
    chk("seq_p0", if_id_pc4, 32'h4); note_fetch();
    step();
    chk("seq_bubble", 32'(if_id_valid), 32'd0);
    pop_gnt("seq_addr1", 32'h4);
    step();
    chk("seq_i1", if_id_inst, inst_of(32'h4));
    chk("seq_p1", if_id_pc4, 32'h8); note_fetch();
    step();
    pop_gnt("seq_addr2", 32'h8);
    step();
    chk("seq_i2", if_id_inst, inst_of(32'h8));
    chk("seq_p2", if_id_pc4, 32'hC); note_fetch();

    // Stall for 3 cycles while the response for 0xC arrives
    stall = 1'b1;
    step();
    chk("stl_hold_a", if_id_inst, inst_of(32'h8));
    step();
    chk("stl_hold_b", if_id_pc4, 32'hC);
    step();
    chk("stl_hold_c", 32'(if_id_valid), 32'd1);
    chk("stl_hold_i", if_id_inst, inst_of(32'h8));
    chk("stl_wait",   32'(dbg_state), 32'(FETCH_WAIT));
    stall = 1'b0;
    step();
    chk("stl_drain_i", if_id_inst, inst_of(32'hC));
    chk("stl_drain_p", if_id_pc4, 32'h10);
    chk("stl_drain_v", 32'(if_id_valid), 32'd1); note_fetch();
    pop_gnt("stl_addr", 32'hC);
    step();
    chk("stl_no_dup", 32'(if_id_valid), 32'd0);
    step();
    chk("stl_next_i", if_id_inst, inst_of(32'h10));
    chk("stl_next_p", if_id_pc4, 32'h14); note_fetch();
    pop_gnt("stl_addr_next", 32'h10);

    // BEQ taken back to 0x08 while the 0x14 request is being granted
    pc_src = PCSRC_BR; id_pc4 = 32'h10; id_imm16 = 16'hFFFE;
    step();
    pc_src = PCSRC_SEQ;
    chk("beq_state", 32'(dbg_state), 32'(FETCH_WAIT));
    chk("beq_bubble_v", 32'(if_id_valid), 32'd0);
    chk("beq_bubble_i", if_id_inst, NOP_INST);
    pop_gnt("beq_wrong_addr", 32'h14); note_kill();
    step();
    chk("beq_killed_v", 32'(if_id_valid), 32'd0);
    chk("beq_req", 32'(imem.req), 32'd1);
    chk("beq_addr", imem.addr, 32'h8);
    step(); step();
    chk("beq_tgt_i", if_id_inst, inst_of(32'h8));
    chk("beq_tgt_p", if_id_pc4, 32'hC); note_fetch();
    pop_gnt("beq_tgt_addr", 32'h8);

    // Jump while in WAIT: in-flight response for 0xC must be dropped
    mem_lat = 3;
    step();
    pc_src = PCSRC_JMP; id_pc4 = 32'hF000_0010; id_jaddr26 = 26'h40;
    step();
    pc_src = PCSRC_SEQ;
    chk("jmp_state", 32'(dbg_state), 32'(FETCH_WAIT));
    chk("jmp_bubble", 32'(if_id_valid), 32'd0);
    step(); step();
    chk("jmp_killed_v", 32'(if_id_valid), 32'd0);
    chk("jmp_req", 32'(imem.req), 32'd1);
    chk("jmp_addr", imem.addr, 32'hF000_0100);
    pop_gnt("jmp_wrong_addr", 32'hC); note_kill();
    wait_valid("jmp_wait", 10);
    chk("jmp_tgt_i", if_id_inst, inst_of(32'hF000_0100));
    chk("jmp_tgt_p", if_id_pc4, 32'hF000_0104); note_fetch();
    pop_gnt("jmp_tgt_addr", 32'hF000_0100);

    // Jump to 0xFFFF_FFFC, then sequential fetch with pc_src = 11 wraps to 0
    mem_lat = 1; pc_src = PCSRC_JMP; id_pc4 = 32'hF000_0000; id_jaddr26 = 26'h3FF_FFFF;
    step();
    pc_src = 2'b11; note_kill();
    step();
    chk("wrap_addr_hi", imem.addr, 32'hFFFF_FFFC);
    pop_gnt("wrap_killed_addr", 32'hF000_0104);
    wait_valid("wrap_wait_hi", 6);
    chk("wrap_hi_i", if_id_inst, inst_of(32'hFFFF_FFFC));
    chk("wrap_hi_p", if_id_pc4, 32'h0);
    chk("wrap_addr_0", imem.addr, 32'h0); note_fetch();
    pop_gnt("wrap_gnt_hi", 32'hFFFF_FFFC);
    wait_valid("wrap_wait_0", 6);
    chk("pc11_i", if_id_inst, inst_of(32'h0));
    chk("pc11_p", if_id_pc4, 32'h4); note_fetch();
    pop_gnt("pc11_addr", 32'h0);

    // Redirect under stall is ignored; re-presented after stall it clears the skid
    pc_src = PCSRC_SEQ; stall = 1'b1;
    step();
    pc_src = PCSRC_BR; id_pc4 = 32'h100; id_imm16 = 16'h0004;
    step();
    chk("stred_hold_i", if_id_inst, inst_of(32'h0));
    chk("stred_state", 32'(dbg_state), 32'(FETCH_WAIT));
    stall = 1'b0;
    step();
    pc_src = PCSRC_SEQ; note_kill();
    chk("stred_bubble", 32'(if_id_valid), 32'd0);
    chk("stred_addr", imem.addr, 32'h110);
    pop_gnt("stred_gnt", 32'h4);
    wait_valid("stred_wait", 6);
    chk("stred_tgt_i", if_id_inst, inst_of(32'h110));
    chk("stred_tgt_p", if_id_pc4, 32'h114); note_fetch();
    pop_gnt("stred_tgt_addr", 32'h110);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 32'(exp_fetched));
    chk("perf_killed",  perf_killed,  32'(exp_killed));
`endif

    // Reset asserted in WAIT; the stale response after release is ignored
    mem_lat = 3;
    step();
    chk("rwait_state", 32'(dbg_state), 32'(FETCH_WAIT));
    rst = 1'b0; gnt_en = 1'b0;
    #1;
    chk("rwait_req",   32'(imem.req), 32'd0);
    chk("rwait_addr",  imem.addr, 32'h0);
    chk("rwait_inst",  if_id_inst, 32'h0);
    chk("rwait_pc4",   if_id_pc4, 32'h0);
    chk("rwait_valid", 32'(if_id_valid), 32'd0);
    chk("rwait_st",    32'(dbg_state), 32'(FETCH_REQ));
`ifdef FETCH_PERF_CNT_EN
    chk("rwait_pf", perf_fetched, 32'd0);
    chk("rwait_pk", perf_killed,  32'd0);
`endif
    step();
    rst = 1'b1;
    step(); step(); step();
    chk("stale_valid", 32'(if_id_valid), 32'd0);
    chk("stale_state", 32'(dbg_state), 32'(FETCH_REQ));
    pop_gnt("stale_gnt", 32'h114);
    mem_lat = 1; gnt_en = 1'b1;
    wait_valid("fresh_wait", 6);
    chk("fresh_i", if_id_inst, inst_of(32'h0));
    chk("fresh_p", if_id_pc4, 32'h4);
    pop_gnt("fresh_addr", 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish within 20000 ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; consumer of the decoder's pcSrc/beq/bne/j redirect outputs.
- Owns the PC, issues requests to instruction memory over a valid/ready handshake and fills the IF/ID register.
- Applies stalls from hazard logic; squashes wrong-path instructions on a branch/jump redirect by injecting NOP (32'h0000_0000).

Parameters:
- ADDR_W, 32, PC / instruction address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- pc_src  in  2  00 = PC+4, 01 = branch, 10 = jump, 11 = treated as 00.
- id_pc4  in  ADDR_W  PC+4 of the instruction currently in ID.
- id_imm16  in  16  branch offset field of the ID instruction.
- id_jaddr26  in  26  jump index field of the ID instruction.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_W  word-aligned fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; exactly one per granted request, in order, at least 1 cycle after grant.
- imem_rdata  in  32  instruction word.
- if_id_inst  out  32  IF/ID instruction.
- if_id_pc4  out  ADDR_W  IF/ID PC+4.
- if_id_valid  out  1  IF/ID holds a real (non-bubble) instruction.

Behaviour:
- Reset (rst = 0, asynchronous):
  - pc = RESET_PC; FSM = REQ; imem_req = 0.
  - if_id_inst = 0, if_id_pc4 = 0, if_id_valid = 0.
  - skid buffer empty; kill = 0.
  - First request is issued in the first cycle after rst deasserts.
- Target arithmetic:
  - branch_tgt = id_pc4 + (sign_extend(id_imm16) << 2), modulo 2^ADDR_W.
  - jump_tgt = {id_pc4[ADDR_W-1:28], id_jaddr26, 2'b00}.
- FSM states:
  - REQ: imem_req = 1, imem_addr = pc. On imem_gnt -> WAIT, and pc advances to pc+4 (wraps at 2^ADDR_W).
  - WAIT: imem_req = 0. On imem_rvalid -> REQ.
  - At most one request is outstanding at a time.
- Response handling:
  - On imem_rvalid with kill = 0 and stall = 0: IF/ID loads {imem_rdata, addr+4}, if_id_valid = 1.
  - If stall = 1: the response goes into a one-entry skid buffer. FSM stays in WAIT (no new request) until the buffer drains.
  - The buffer drains into IF/ID on the first cycle with stall = 0.
- Stall:
  - IF/ID and pc hold.
  - A request already in REQ keeps imem_req asserted (request is not dropped).
- Redirect (pc_src = 01/10, stall = 0):
  - pc = target in the same cycle (next edge).
  - IF/ID loads NOP with if_id_valid = 0 (one-bubble flush).
  - Skid buffer cleared.
  - If in WAIT, kill = 1 and the in-flight response is discarded on its rvalid; the FSM then returns to REQ at the new pc.
  - If in REQ with gnt in the same cycle, that grant's data is also killed.
- Redirect with stall = 1 simultaneously: stall wins; the redirect is re-presented by ID next cycle (ID holds).
- pc_src = 11 behaves exactly as 00.
- No response yet and no stall: IF/ID loads a bubble (valid = 0, inst = NOP) each cycle.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds outputs perf_fetched[31:0] (responses delivered to IF/ID with valid = 1) and perf_killed[31:0] (responses discarded by kill, plus skid entries cleared by redirect).
- Both counters reset to 0, wrap at 2^32, and are read-only.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - NOP_INST constant.
  - pc_src encodings (PCSRC_SEQ, PCSRC_BR, PCSRC_JMP).
  - Opcode constants LW/SW/BEQ/BNE/J/RTYPE.
  - Fetch FSM state typedef.
- One sub-module, fetch_skid_buf: one-entry {inst, pc4} buffer with push/pop/clear, full flag, and asynchronous active-low reset.

Test Plan:
- Reset release, imem grants immediately, rvalid 1 cycle later -> addresses 0x0, 0x4, 0x8; IF/ID valid with pc4 0x4, 0x8, 0xC.
- BEQ taken: id_pc4 = 0x10, imm16 = 16'hFFFE, pc_src = 01 -> next imem_addr 0x08; IF/ID bubble for 1 cycle; no instruction from 0x14 reaches IF/ID.
- Jump while in WAIT: id_pc4 = 0xF000_0010, jaddr26 = 26'h40, pc_src = 10 -> in-flight response dropped (perf_killed +1 if enabled); next imem_addr 0xF000_0100.
- stall held 3 cycles while rvalid arrives -> IF/ID unchanged for 3 cycles; skid holds the word; it is released on the first cycle after stall falls; no duplicate or lost instruction.
- pc at 0xFFFF_FFFC, sequential -> next imem_addr 0x0000_0000; pc_src = 11 -> same as 00.
- rst asserted while in WAIT -> all outputs return to reset values immediately; the stale rvalid arriving after release is ignored until a fresh request is granted.
